// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter/sequencer for the single data-memory port of the MIPS core.
// Port 0 (core) has fixed priority; port 1 is forced after STARVE_MAX lost rounds.
module mem_bus_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  gnt
);

    localparam logic [2:0] LP_LAT    = 3'(RD_LAT);
    localparam logic [2:0] LP_STARVE = 3'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_starve;
    logic [2:0]  r_lat;
    logic        r_owner;
    logic        r_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic        w_any_req;
    logic        w_pick1;

    assign w_any_req = m0_req | m1_req;
    // Port 1 wins when alone, or when it has lost STARVE_MAX rounds in a row.
    assign w_pick1   = m1_req & (~m0_req | (r_starve == LP_STARVE));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next = ISSUE;
            ISSUE:   w_next = r_we ? ACK : RDWAIT;
            RDWAIT:  if (r_lat == 3'd1) w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_starve    <= 3'd0;
            r_lat       <= 3'd0;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_m0_rdata  <= 32'd0;
            r_m1_rdata  <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (!m1_req || w_pick1) begin
                        r_starve <= 3'd0;
                    end else if (m0_req && r_starve != 3'd7) begin
                        r_starve <= r_starve + 3'd1;
                    end
                    // All access fields are captured here so requester changes in flight are ignored.
                    if (w_any_req) begin
                        r_owner     <= w_pick1;
                        r_we        <= w_pick1 ? m1_we    : m0_we;
                        r_mem_addr  <= w_pick1 ? m1_addr  : m0_addr;
                        r_mem_wdata <= w_pick1 ? m1_wdata : m0_wdata;
                    end
                end
                ISSUE: begin
                    if (!r_we) r_lat <= LP_LAT;
                end
                RDWAIT: begin
                    r_lat <= r_lat - 3'd1;
                    if (r_lat == 3'd1) begin
                        if (r_owner) r_m1_rdata <= mem_rdata;
                        else         r_m0_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_read  = (r_state == ISSUE) & ~r_we;
    assign mem_write = (r_state == ISSUE) &  r_we;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign m0_ack    = (r_state == ACK) & ~r_owner;
    assign m1_ack    = (r_state == ACK) &  r_owner;
    assign gnt       = (r_state == IDLE) ? 2'b00 : {r_owner, ~r_owner};

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and sequencer for the single data-memory port of the pipelined MIPS core. Requester 0 is the core MEM stage; requester 1 is a secondary bus master such as a DMA or debug loader. The block serialises requests onto one synchronous memory port, inserts the configured read latency, and returns a one-cycle acknowledge. The core stalls while its request is pending and unacknowledged. Arbitration is fixed-priority to the core, with an anti-starvation counter for requester 1.

## Interface
- RD_LAT, 1, memory read latency in cycles (legal 1..7)
- STARVE_MAX, 4, consecutive port-0 grants while port 1 waits before port 1 is forced (legal 1..7)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  port 0 request; held with m0_we/m0_addr/m0_wdata stable until m0_ack
- m0_we  in  1  port 0: 1 = write, 0 = read
- m0_addr  in  32  port 0 byte address
- m0_wdata  in  32  port 0 write data
- m0_rdata  out  32  port 0 read data, registered, valid while m0_ack=1 and held until the next port-0 read completes
- m0_ack  out  1  port 0 one-cycle completion pulse
- m1_req, m1_we, m1_addr[31:0], m1_wdata[31:0], m1_rdata[31:0], m1_ack: identical semantics for port 1
- mem_addr  out  32  memory address, registered
- mem_read  out  1  memory read strobe, one cycle per access
- mem_write  out  1  memory write strobe, one cycle per access
- mem_wdata  out  32  memory write data, registered
- mem_rdata  in  32  memory read data, valid RD_LAT cycles after the mem_read cycle
- gnt  out  2  one-hot owner: [0] = port 0, [1] = port 1; 0 when idle

## Operation
- FSM states: IDLE, ISSUE, RDWAIT, ACK.
- IDLE: sample requests and choose a winner.
  - Only m1_req set: grant port 1.
  - Only m0_req set: grant port 0.
  - Both set: port 0 wins unless starve_cnt == STARVE_MAX, in which case port 1 wins.
  - On any grant, latch the winner's we/addr/wdata into mem_* registers and go to ISSUE. No request: stay in IDLE.
- ISSUE (one cycle):
  - mem_read = ~we, mem_write = we, mem_addr and mem_wdata driven.
  - Write: go to ACK. Read: go to RDWAIT with lat_cnt = RD_LAT.
- RDWAIT: decrement lat_cnt each cycle. In the cycle lat_cnt == 1, sample mem_rdata into the winner's mX_rdata and go to ACK.
- ACK (one cycle): assert the winner's mX_ack, then go to IDLE. Requests are not sampled in ACK.
- starve_cnt (3 bits, saturating) updates only on an IDLE grant:
  - Port 0 granted while m1_req = 1: increment.
  - Port 1 granted: clear.
  - m1_req = 0 in IDLE: clear.
- gnt is one-hot for the winner from ISSUE through ACK, and 0 in IDLE.
- The non-granted port's rdata and ack are untouched.
- A requester that holds req high through the cycle after its ack starts a new transaction, so requesters must drop req on the edge after ack.

## Timing
- Reset (reset = 0), applied immediately and asynchronously, including mid-transaction:
  - State IDLE; starve_cnt = 0; lat_cnt = 0.
  - mem_read = mem_write = 0; mem_addr = mem_wdata = 0.
  - m0_ack = m1_ack = 0; m0_rdata = m1_rdata = 0; gnt = 0.
  - An aborted access produces no ack. After reset releases, the first grant occurs in the first IDLE cycle.
- Request sampled in IDLE cycle t: strobe in cycle t+1.
  - Write: ack in cycle t+2.
  - Read: mem_rdata sampled at the end of cycle t+1+RD_LAT; ack and rdata valid in cycle t+2+RD_LAT.
- Throughput per access: write 3 cycles, read 3+RD_LAT cycles, including the IDLE decision cycle.
- mem_read and mem_write are never both high, and each is high for exactly one cycle per access.
- Requests raised during ISSUE, RDWAIT or ACK wait until the next IDLE cycle.
- Input changes while a request is in flight are ignored, because all access fields are latched in IDLE.

## Test plan
- Reset, then a single port-0 write (addr 0x00000010, data 0xDEADBEEF): mem_write pulses 1 cycle after the request with those values; m0_ack pulses 2 cycles after the request; m1_ack stays 0.
- RD_LAT = 2, port-1 read of 0x00000020 with mem_rdata = 0x12345678 driven 2 cycles after mem_read: m1_ack in cycle t+4 with m1_rdata = 0x12345678; m0_rdata unchanged at 0.
- Both ports requesting continuously, STARVE_MAX = 4, port 0 re-requesting after each ack: grant sequence is 0,0,0,0,1,0,0,0,0,1; starve_cnt returns to 0 after each port-1 grant.
- Port-0 read with m0_addr changed to 0xFFFFFFFF during RDWAIT: mem_addr keeps the originally latched value; the ack arrives at normal latency.
- reset asserted during RDWAIT of a port-0 read: all outputs go to 0 immediately; no m0_ack is ever produced; a new port-1 write after release completes normally in 3 cycles.
